// File: rtl/collision_pkg.sv
// Shared constants, state encoding and player record for the collision scheduler.
package collision_pkg;

  localparam logic [3:0]  TILE_AIR   = 4'h2;
  localparam int unsigned MAP_W      = 160;
  localparam int unsigned MAP_H      = 30;
  localparam int unsigned MAP_SIZE   = 4800;
  localparam int unsigned TILE_SHIFT = 4;

  localparam int PROBE_DX = 19;
  localparam int PROBE_DY = 25;
  localparam int SIDE_DX  = 20;
  localparam int SIDE_DY  = 24;

  localparam int unsigned NUM_PROBES        = 14;
  localparam int unsigned PROBES_PER_PLAYER = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    P_DOWN1,
    P_DOWN2,
    P_UP,
    P_UP1,
    P_UP2,
    P_SIDE_A,
    P_SIDE_B
  } probe_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] ysig;
    logic        dir;
  } player_t;

  function automatic logic is_air(input logic [3:0] code);
    return code == TILE_AIR;
  endfunction

endpackage

// File: rtl/collision_scheduler_if.sv
// Tile RAM port and map-editor write request shared by the scheduler and its environment.
interface collision_scheduler_if;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/collision_scheduler_tile_addr_calc.sv
// Pixel position to linear tile index, flagging probes that fall outside the map.
module tile_addr_calc
  import collision_pkg::*;
(
  input  logic signed [13:0] px,
  input  logic signed [13:0] py,
  output logic        [12:0] addr,
  output logic               out_of_range
);

  logic [9:0]  tile_x;
  logic [9:0]  tile_y;
  logic [17:0] lin;

  // Sum is kept wide so a large y cannot wrap back under the map size.
  always_comb begin
    tile_x       = px[13:TILE_SHIFT];
    tile_y       = py[13:TILE_SHIFT];
    lin          = 18'(tile_x) + 18'(tile_y) * 18'(MAP_W);
    out_of_range = px[13] | py[13]
                 | (px[12:0] >= 13'(MAP_W << TILE_SHIFT))
                 | (lin >= 18'(MAP_SIZE));
    addr         = out_of_range ? '0 : lin[12:0];
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scan: 14 tile probes through a shared RAM port, map-editor writes when idle.
module collision_scheduler
  import collision_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [11:0]           blue_x,
  input  logic [11:0]           blue_y,
  input  logic [11:0]           blue_ysig,
  input  logic [11:0]           red_x,
  input  logic [11:0]           red_y,
  input  logic [11:0]           red_ysig,
  input  logic                  x_direction_blue,
  input  logic                  x_direction_red,
  collision_scheduler_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  movex_blue,
  output logic                  movey_blue,
  output logic                  test_jump_blue,
  output logic                  movex_red,
  output logic                  movey_red,
  output logic                  test_jump_red
);

  state_t  state;
  player_t blue_q;
  player_t red_q;

  logic [3:0]  probe_idx;
  logic [1:0]  drain_cnt;
  logic        pipe1_vld, pipe2_vld;
  logic [3:0]  pipe1_idx, pipe2_idx;
  logic        pipe1_oor, pipe2_oor;
  logic [13:0] air;

  player_t            cur;
  logic [2:0]         slot;
  logic signed [13:0] base_x, base_y, off_x, off_y, px, py;
  logic [12:0]        probe_addr;
  logic               probe_oor;
  logic               blue_down, red_down;

  always_comb begin
    if (probe_idx >= 4'(PROBES_PER_PLAYER)) begin
      cur  = red_q;
      slot = 3'(probe_idx - 4'(PROBES_PER_PLAYER));
    end else begin
      cur  = blue_q;
      slot = probe_idx[2:0];
    end
    base_x = signed'({2'b00, cur.x});
    base_y = signed'({2'b00, cur.y});
    off_x  = '0;
    off_y  = '0;
    case (probe_t'(slot))
      P_DOWN1:  begin off_x = -14'(PROBE_DX); off_y =  14'(PROBE_DY); end
      P_DOWN2:  begin off_x =  14'(PROBE_DX); off_y =  14'(PROBE_DY); end
      P_UP:     begin off_x = '0;             off_y = -14'(PROBE_DY); end
      P_UP1:    begin off_x = -14'(PROBE_DX); off_y = -14'(PROBE_DY); end
      P_UP2:    begin off_x =  14'(PROBE_DX); off_y = -14'(PROBE_DY); end
      P_SIDE_A: begin off_x = cur.dir ? 14'(SIDE_DX) : -14'(SIDE_DX); off_y =  14'(SIDE_DY); end
      P_SIDE_B: begin off_x = cur.dir ? 14'(SIDE_DX) : -14'(SIDE_DX); off_y = -14'(SIDE_DY); end
      default:  ;
    endcase
    px = base_x + off_x;
    py = base_y + off_y;
  end

  tile_addr_calc u_addr_calc (
    .px           (px),
    .py           (py),
    .addr         (probe_addr),
    .out_of_range (probe_oor)
  );

  always_comb begin
    blue_down = blue_q.y > blue_q.ysig;
    red_down  = red_q.y > red_q.ysig;
  end

  // Probe k is issued at edge k+1, read by the RAM at k+2 and scored at k+3;
  // the last score lands one edge before the flags are combined.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      movex_blue     <= 1'b0;
      movey_blue     <= 1'b0;
      test_jump_blue <= 1'b0;
      movex_red      <= 1'b0;
      movey_red      <= 1'b0;
      test_jump_red  <= 1'b0;
      blue_q         <= '0;
      red_q          <= '0;
      probe_idx      <= '0;
      drain_cnt      <= '0;
      pipe1_vld      <= 1'b0;
      pipe2_vld      <= 1'b0;
      pipe1_idx      <= '0;
      pipe2_idx      <= '0;
      pipe1_oor      <= 1'b0;
      pipe2_oor      <= 1'b0;
      air            <= '0;
      bus.wr_ack     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
    end else begin
      done       <= 1'b0;
      bus.wr_ack <= 1'b0;
      bus.mem_we <= 1'b0;
      pipe1_vld  <= 1'b0;
      pipe2_vld  <= pipe1_vld;
      pipe2_idx  <= pipe1_idx;
      pipe2_oor  <= pipe1_oor;
      if (pipe2_vld) begin
        air[pipe2_idx] <= !pipe2_oor && is_air(bus.mem_rdata);
      end

      case (state)
        IDLE: begin
          if (start) begin
            blue_q    <= '{x: blue_x, y: blue_y, ysig: blue_ysig, dir: x_direction_blue};
            red_q     <= '{x: red_x, y: red_y, ysig: red_ysig, dir: x_direction_red};
            probe_idx <= '0;
            busy      <= 1'b1;
            state     <= LATCH;
          end else if (bus.wr_req) begin
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
            bus.mem_we    <= bus.wr_addr < 13'(MAP_SIZE);
            bus.wr_ack    <= 1'b1;
          end
        end
        LATCH, ISSUE: begin
          bus.mem_addr <= probe_addr;
          pipe1_vld    <= 1'b1;
          pipe1_idx    <= probe_idx;
          pipe1_oor    <= probe_oor;
          probe_idx    <= probe_idx + 4'd1;
          if (probe_idx == 4'(NUM_PROBES - 1)) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            state <= ISSUE;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) begin
            movex_blue     <= air[5] & air[6];
            movey_blue     <= blue_down ? (air[0] & air[1]) : (air[3] & air[4]);
            test_jump_blue <= (!air[0] | !air[1]) & air[2];
            movex_red      <= air[12] & air[13];
            movey_red      <= red_down ? (air[7] & air[8]) : (air[10] & air[11]);
            test_jump_red  <= (!air[7] | !air[8]) & air[9];
            done           <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a behavioural single-port tile RAM.
module tb_collision_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] blue_x = '0, blue_y = '0, blue_ysig = '0;
  logic [11:0] red_x = '0, red_y = '0, red_ysig = '0;
  logic        x_direction_blue = 1'b0, x_direction_red = 1'b0;
  logic        busy, done;
  logic        movex_blue, movey_blue, test_jump_blue;
  logic        movex_red, movey_red, test_jump_red;
  logic        fill_air = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [3:0]  ram [0:4799];
  logic [12:0] seen_addr [14];
  int          done_cyc, done_cnt;
  logic        we_during, busy_c1, busy_last;

  collision_scheduler_if bus();

  collision_scheduler dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .start            (start),
    .blue_x           (blue_x),
    .blue_y           (blue_y),
    .blue_ysig        (blue_ysig),
    .red_x            (red_x),
    .red_y            (red_y),
    .red_ysig         (red_ysig),
    .x_direction_blue (x_direction_blue),
    .x_direction_red  (x_direction_red),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .movex_blue       (movex_blue),
    .movey_blue       (movey_blue),
    .test_jump_blue   (test_jump_blue),
    .movex_red        (movex_red),
    .movey_red        (movey_red),
    .test_jump_red    (test_jump_red)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (fill_air) begin
      for (int i = 0; i < 4800; i++) ram[i] <= 4'h2;
    end else if (bus.mem_we && bus.mem_addr < 13'd4800) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= (bus.mem_addr < 13'd4800) ? ram[bus.mem_addr] : 4'hF;
  end

  task automatic set_players(input logic [11:0] bx, by, bys, input logic bd,
                             input logic [11:0] rx, ry, rys, input logic rd);
    blue_x = bx; blue_y = by; blue_ysig = bys; x_direction_blue = bd;
    red_x = rx;  red_y = ry;  red_ysig = rys;  x_direction_red = rd;
  endtask

  task automatic run_scan(input int extra_start, input int wr_cyc,
                          input int change_cyc, input int last_cyc);
    done_cyc = -1; done_cnt = 0; we_during = 1'b0; busy_c1 = 1'b0; busy_last = 1'b1;
    @(negedge Clk); start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    for (int c = 1; c <= last_cyc; c++) begin
      if (c == extra_start) start = 1'b1;
      if (c == wr_cyc) begin
        bus.wr_req = 1'b1; bus.wr_addr = 13'd50; bus.wr_data = 4'h7;
      end
      if (c == change_cyc) begin
        set_players(12'd3000, 12'd5, 12'd900, ~x_direction_blue,
                    12'd7, 12'd4000, 12'd0, ~x_direction_red);
      end
      @(posedge Clk); #1; start = 1'b0;
      if (c <= 14) seen_addr[c-1] = bus.mem_addr;
      if (bus.mem_we) we_during = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1) busy_c1 = busy;
      if (c == last_cyc) busy_last = busy;
    end
  endtask

  task automatic check_timing(input string name);
    checks++;
    if (done_cyc !== 17 || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done: got cycle=%0d pulses=%0d expected cycle=17 pulses=1", name, done_cyc, done_cnt);
    end
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp_b, input logic [2:0] exp_r);
    checks++;
    if ({movex_blue, movey_blue, test_jump_blue} !== exp_b) begin
      errors++;
      $display("FAIL %s_blue: got %b expected %b", name, {movex_blue, movey_blue, test_jump_blue}, exp_b);
    end
    checks++;
    if ({movex_red, movey_red, test_jump_red} !== exp_r) begin
      errors++;
      $display("FAIL %s_red: got %b expected %b", name, {movex_red, movey_red, test_jump_red}, exp_r);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({busy, done, movex_blue, movey_blue, test_jump_blue, movex_red, movey_red,
         test_jump_red, bus.wr_ack, bus.mem_we} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, movex_blue, movey_blue,
               test_jump_blue, movex_red, movey_red, test_jump_red, bus.wr_ack, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== 13'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr);
    end
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic test_all_air;
    logic [12:0] exp_addr [14];
    exp_addr = '{13'd1125, 13'd1127, 13'd646, 13'd645, 13'd647, 13'd1127, 13'd647,
                 13'd3211, 13'd3213, 13'd2732, 13'd2731, 13'd2733, 13'd3211, 13'd2731};
    @(negedge Clk); fill_air = 1'b1;
    @(negedge Clk); fill_air = 1'b0;
    set_players(12'd100, 12'd100, 12'd100, 1'b1, 12'd200, 12'd300, 12'd300, 1'b0);
    run_scan(0, 0, 2, 18);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (seen_addr[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL air_probe%0d: got addr %0d expected %0d", k, seen_addr[k], exp_addr[k]);
      end
    end
    check_timing("air");
    checks++;
    if (we_during !== 1'b0 || busy_c1 !== 1'b1 || busy_last !== 1'b0) begin
      errors++;
      $display("FAIL air_busy_we: got we=%b busy1=%b busy18=%b expected 0 1 0", we_during, busy_c1, busy_last);
    end
    check_flags("air", 3'b110, 3'b110);
  endtask

  task automatic test_back_to_back;
    @(negedge Clk); bus.wr_req = 1'b1; bus.wr_data = 4'h5;
    for (int i = 0; i < 160; i++) begin
      bus.wr_addr = 13'(1280 + i);
      @(posedge Clk); #1;
      checks++;
      if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 13'(1280 + i) ||
          bus.mem_wdata !== 4'h5) begin
        errors++;
        $display("FAIL b2b_write%0d: got ack=%b we=%b addr=%0d data=%h expected 1 1 %0d 5",
                 i, bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata, 1280 + i);
      end
    end
    bus.wr_req = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.mem_we !== 1'b0 || ram[1280] !== 4'h5 || ram[1439] !== 4'h5) begin
      errors++;
      $display("FAIL b2b_end: got ack=%b we=%b ram1280=%h ram1439=%h expected 0 0 5 5",
               bus.wr_ack, bus.mem_we, ram[1280], ram[1439]);
    end
  endtask

  task automatic test_solid_row;
    set_players(12'd100, 12'd104, 12'd100, 1'b1, 12'd200, 12'd300, 12'd300, 1'b0);
    run_scan(0, 0, 0, 18);
    check_timing("row8");
    check_flags("row8", 3'b001, 3'b110);
  endtask

  task automatic test_bottom_edge;
    set_players(12'd100, 12'd470, 12'd470, 1'b1, 12'd200, 12'd300, 12'd300, 1'b0);
    run_scan(0, 0, 0, 18);
    check_timing("bottom");
    checks++;
    if (seen_addr[2] !== 13'd4326) begin
      errors++;
      $display("FAIL bottom_up_addr: got %0d expected 4326", seen_addr[2]);
    end
    check_flags("bottom", 3'b011, 3'b110);
  endtask

  task automatic test_write_during_scan;
    int ack_cyc;
    ack_cyc = -1;
    set_players(12'd100, 12'd100, 12'd100, 1'b1, 12'd200, 12'd300, 12'd300, 1'b0);
    run_scan(0, 3, 0, 18);
    check_timing("wrscan");
    checks++;
    if (we_during !== 1'b0) begin
      errors++;
      $display("FAIL wrscan_we: got mem_we seen=%b expected 0", we_during);
    end
    for (int c = 19; c <= 24; c++) begin
      @(posedge Clk); #1;
      if (bus.wr_ack) begin
        ack_cyc = c;
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd50 || bus.mem_wdata !== 4'h7) begin
          errors++;
          $display("FAIL wrscan_write: got we=%b addr=%0d data=%h expected 1 50 7",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.wr_req = 1'b0;
        break;
      end
    end
    bus.wr_req = 1'b0;
    checks++;
    if (ack_cyc !== 19) begin
      errors++;
      $display("FAIL wrscan_ack_cycle: got %0d expected 19", ack_cyc);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.mem_we !== 1'b0 || ram[50] !== 4'h7) begin
      errors++;
      $display("FAIL wrscan_single: got ack=%b we=%b ram50=%h expected 0 0 7", bus.wr_ack, bus.mem_we, ram[50]);
    end
  endtask

  task automatic test_oor_write;
    @(negedge Clk); bus.wr_req = 1'b1; bus.wr_addr = 13'd4800; bus.wr_data = 4'h3;
    @(posedge Clk); #1;
    bus.wr_req = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got ack=%b we=%b expected 1 0", bus.wr_ack, bus.mem_we);
    end
  endtask

  task automatic test_double_start;
    run_scan(5, 0, 0, 30);
    check_timing("dblstart");
    check_flags("dblstart", 3'b110, 3'b110);
  endtask

  task automatic test_reset_mid_scan;
    logic seen;
    seen = 1'b0;
    @(negedge Clk); start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    repeat (7) @(posedge Clk);
    #1; Reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, movex_blue, movey_blue, test_jump_blue, movex_red, movey_red,
         test_jump_red, bus.mem_we} !== 9'b0 || bus.mem_addr !== 13'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %b addr=%0d expected 0 0", {busy, done, movex_blue,
               movey_blue, test_jump_blue, movex_red, movey_red, test_jump_red, bus.mem_we}, bus.mem_addr);
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk); Reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone: got done/busy seen=%b expected 0", seen);
    end
    run_scan(0, 0, 0, 18);
    check_timing("midreset_restart");
    check_flags("midreset_restart", 3'b110, 3'b110);
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset;
    test_all_air;
    test_back_to_back;
    test_solid_row;
    test_bottom_edge;
    test_write_during_scan;
    test_oor_write;
    test_double_start;
    test_reset_mid_scan;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle frame pulse requesting a collision scan.
REQ-004 blue_x, blue_y, blue_ysig  input  12 each  blue player next/current position and previous y.
REQ-005 red_x, red_y, red_ysig  input  12 each  red player, same meaning.
REQ-006 x_direction_blue, x_direction_red  input  1 each  1=moving right, 0=left.
REQ-007 wr_req  input  1  level request from the map editor to write one tile.
REQ-008 wr_addr  input  13  tile index to write.
REQ-009 wr_data  input  4  tile code to write.
REQ-010 wr_ack  output  1  one-cycle pulse when the write is issued.
REQ-011 mem_addr  output  13  shared single-port tile RAM address.
REQ-012 mem_we  output  1  tile RAM write enable.
REQ-013 mem_wdata  output  4  tile RAM write data.
REQ-014 mem_rdata  input  4  tile RAM read data, valid one cycle after address.
REQ-015 busy  output  1  high from the cycle after start is accepted through done.
REQ-016 done  output  1  one-cycle pulse when all result flags update.
REQ-017 movex_blue, movey_blue, test_jump_blue, movex_red, movey_red, test_jump_red  output  1 each  collision results.

Function
REQ-018 States: IDLE, LATCH, ISSUE, DRAIN, DONE; IDLE->LATCH on start; LATCH->ISSUE; ISSUE->DRAIN after 14th probe address; DRAIN->DONE; DONE->IDLE.
REQ-019 LATCH captures all position/direction inputs; later input changes do not affect the scan.
REQ-020 Probe order per player (blue probes 0-6, then red 7-13): down1(x-19,y+25), down2(x+19,y+25), up(x,y-25), up1(x-19,y-25), up2(x+19,y-25), sideA(x±20,y+24), sideB(x±20,y-24); ± is + when x_direction=1.
REQ-021 Probe address = (px>>4) + (py>>4)*160, computed in 14-bit signed arithmetic.
REQ-022 Probe with px<0, py<0, px>=2560 or address>=4800 is not read and SHALL be scored solid.
REQ-023 ISSUE drives one probe address per cycle, mem_we=0; mem_rdata of probe k is scored in the following cycle.
REQ-024 A tile is air iff code==4'h2; every other code is solid.
REQ-025 test_jump = (!air(down1) | !air(down2)) & air(up).
REQ-026 Moving down iff y > ysig (unsigned 12-bit); movey = down ? air(down1)&air(down2) : air(up1)&air(up2).
REQ-027 movex = air(sideA) & air(sideB).
REQ-028 Latency: start sampled at cycle 0 -> done and all six flags update at cycle 17; flags hold otherwise.
REQ-029 start while busy is ignored.
REQ-030 In IDLE with wr_req=1 and start=0: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1 for one cycle; FSM stays IDLE.
REQ-031 start and wr_req in the same IDLE cycle: start wins; write waits until FSM returns to IDLE.
REQ-032 wr_addr>=4800: wr_ack pulses, mem_we stays 0.
REQ-033 Back-to-back: wr_req held high yields one write per cycle in IDLE.

Reset
REQ-034 Reset_n low: state=IDLE, all flags, busy, done, wr_ack, mem_we =0, mem_addr=0.
REQ-035 Reset mid-scan aborts; no done; flags return to 0; next start begins a fresh scan.

Structure
REQ-036 Package collision_pkg holds TILE_AIR=4'h2, MAP_W=160, MAP_H=30, MAP_SIZE=4800, TILE_SHIFT=4, probe offset constants, state enum.
REQ-037 One sub-module tile_addr_calc: combinational (px,py) -> address plus out_of_range flag.

Verification
REQ-038 All-air map, blue (100,100), ysig=100, dir=1, start -> addresses 1125,1127,... in order, done at cycle 17, movex=1, movey=1, test_jump=0.
REQ-039 Row 8 (tiles 1280-1439) solid, blue y=104, ysig=100 -> test_jump_blue=1, movey_blue=0.
REQ-040 Blue y=470 (y+25 in row 30) -> no RAM read for down probes, test_jump_blue=1 if up air.
REQ-041 wr_req asserted cycle 3 of a scan -> mem_we=0 until IDLE, then single write, wr_ack pulse, correct addr/data.
REQ-042 Reset_n low at cycle 8 of scan -> flags 0, no done; new start completes normally 17 cycles later.
REQ-043 Second start at cycle 5 -> ignored, exactly one done pulse.
